// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock front panel: repeat-state encoding,
// default tick timing and the button channel index map.
package clock_pkg;

  // Auto-repeat FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Default timing, in sample ticks (190 Hz tick assumed)
  localparam int DEB_TICKS_DEF    = 4;
  localparam int REPEAT_DELAY_DEF = 95;
  localparam int REPEAT_RATE_DEF  = 38;

  // Button channel indices on btn_raw / btn_* buses
  localparam int BTN_ADD_H = 0;
  localparam int BTN_ADD_M = 1;
  localparam int BTN_VIEW  = 2;

  // Larger of two integers, used to size shared counters
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// One button channel: two-flop synchroniser, tick-paced debounce, press pulse
// and (with BTN_AUTOREPEAT_EN defined) the hold-to-repeat FSM. Without the
// macro the repeat output is simply the press pulse.
module btn_cond_ch
  import clock_pkg::*;
#(
  parameter int DEB_TICKS    = DEB_TICKS_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rep
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_TICKS - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic [7:0] deb_cnt_reg;
  logic [7:0] deb_cnt_next;
  logic       level_reg;
  logic       level_next;
  logic       level_d_reg;
  logic       press_reg;
  logic       rise;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce: the DEB_TICKS-th consecutive disagreeing sample flips the level
  always_comb begin
    deb_cnt_next = deb_cnt_reg;
    level_next   = level_reg;
    if (tick) begin
      if (sync2_reg == level_reg) begin
        deb_cnt_next = 8'd0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        level_next   = ~level_reg;
        deb_cnt_next = 8'd0;
      end else begin
        deb_cnt_next = deb_cnt_reg + 8'd1;
      end
    end
  end

  // Debounce state, delayed level for edge detect, registered press pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      deb_cnt_reg <= 8'd0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      press_reg   <= 1'b0;
    end else begin
      deb_cnt_reg <= deb_cnt_next;
      level_reg   <= level_next;
      level_d_reg <= level_reg;
      press_reg   <= rise;
    end
  end

  // High for the first cycle the debounced level is 1
  assign rise  = level_reg & ~level_d_reg;
  assign level = level_reg;
  assign press = press_reg;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(imax(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  rep_state_t       state_reg;
  rep_state_t       state_next;
  logic [REP_W-1:0] rep_cnt_reg;
  logic [REP_W-1:0] rep_cnt_next;
  logic             rep_reg;
  logic             rep_next;

  // Repeat FSM; a falling level (including one landing this very tick)
  // wins over a repeat that would be due in the same cycle
  always_comb begin
    state_next   = state_reg;
    rep_cnt_next = rep_cnt_reg;
    rep_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          rep_next     = 1'b1;
          rep_cnt_next = '0;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        if (!level_next) begin
          rep_cnt_next = '0;
          state_next   = IDLE;
        end else if (tick) begin
          if (rep_cnt_reg == DELAY_LAST) begin
            rep_next     = 1'b1;
            rep_cnt_next = '0;
            state_next   = REPEAT;
          end else begin
            rep_cnt_next = rep_cnt_reg + REP_W'(1);
          end
        end
      end
      REPEAT: begin
        if (!level_next) begin
          rep_cnt_next = '0;
          state_next   = IDLE;
        end else if (tick) begin
          if (rep_cnt_reg == RATE_LAST) begin
            rep_next     = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt_reg + REP_W'(1);
          end
        end
      end
      default: begin
        rep_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  // Repeat FSM state, counter and registered repeat pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= IDLE;
      rep_cnt_reg <= '0;
      rep_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rep_cnt_reg <= rep_cnt_next;
      rep_reg     <= rep_next;
    end
  end

  assign rep = rep_reg;
`else
  // Repeat timing has no effect in this build; the empty block keeps both
  // builds on one parameter interface with every parameter referenced.
  if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_rep_cfg_unused
  end

  assign rep = press_reg;
`endif

endmodule

// File: rtl/btn_cond.sv
// Front-panel button conditioner: N_BTN independent channels turning raw
// bouncy buttons into debounced levels, press pulses and repeat pulses.
// Optional macro BTN_AUTOREPEAT_EN enables hold-to-repeat on btn_rep;
// without it btn_rep equals btn_press.
module btn_cond
  import clock_pkg::*;
#(
  parameter int N_BTN        = 3,
  parameter int DEB_TICKS    = DEB_TICKS_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rep
);

  genvar gi;

  // One fully independent conditioner per button
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_cond_ch #(
        .DEB_TICKS    (DEB_TICKS),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
        .clk   (clk),
        .clr   (clr),
        .tick  (tick),
        .raw   (btn_raw[gi]),
        .level (btn_level[gi]),
        .press (btn_press[gi]),
        .rep   (btn_rep[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with a pulse scoreboard: expected press/repeat
// pulses (cycle, channel) are queued when stimulus is applied and popped as
// the DUT emits them. Tick strobes every 4 clk.
module tb_btn_cond;

  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RR  = 3;
  localparam int TP  = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         tick;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_rep;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int press_q[$];
  int rep_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_cond #(
    .N_BTN        (N),
    .DEB_TICKS    (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .tick      (tick),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .btn_rep   (btn_rep)
  );

  // First tick edge at or after cycle c (tick edges are multiples of TP)
  function automatic int first_tick(input int c);
    return ((c + TP - 1) / TP) * TP;
  endfunction

  // Edge at which the level flips for a raw change driven at negedge c:
  // two sync flops, then DEB consecutive ticks
  function automatic int flip_at(input int c);
    return first_tick(c + 3) + (DEB - 1) * TP;
  endfunction

  task automatic step();
    @(negedge clk);
    tick = (((cyc + 1) % TP) == 0);
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) step();
  endtask

  task automatic align();
    while ((cyc % TP) != 1) step();
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int k, input int ch);
    press_q.push_back(k * 8 + ch);
    rep_q.push_back(k * 8 + ch);
  endtask

  task automatic expect_rep(input int k, input int ch);
`ifdef BTN_AUTOREPEAT_EN
    rep_q.push_back(k * 8 + ch);
`else
    if (k < 0 || ch < 0) $display("note: bad repeat expectation");
`endif
  endtask

  // Scoreboard side: every pulse seen is matched against the queue head
  // (code = cycle*8 + channel, -1 = nothing expected)
  task automatic check_pulses();
    for (int ch = 0; ch < N; ch++) begin
      if (btn_press[ch] !== 1'b0) begin
        int got;
        int exp;
        got = cyc * 8 + ch;
        exp = (press_q.size() > 0) ? press_q.pop_front() : -1;
        vectors++;
        $display("cycle %0d: btn_press ch%0d", cyc, ch);
        assert (got === exp) else begin
          miscompares++;
          $error("FAIL press_pulse: observed code %0d expected code %0d", got, exp);
        end
      end
      if (btn_rep[ch] !== 1'b0) begin
        int got;
        int exp;
        got = cyc * 8 + ch;
        exp = (rep_q.size() > 0) ? rep_q.pop_front() : -1;
        vectors++;
        $display("cycle %0d: btn_rep ch%0d", cyc, ch);
        assert (got === exp) else begin
          miscompares++;
          $error("FAIL rep_pulse: observed code %0d expected code %0d", got, exp);
        end
      end
    end
  endtask

  initial begin
    int c;
    int f;
    int fr;

    clr     = 1'b1;
    tick    = 1'b0;
    btn_raw = '0;

    fork
      forever begin
        @(negedge clk);
        if (clr === 1'b0) check_pulses();
      end
      begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) step();
    check_vec("reset_level", btn_level, 3'b000);
    check_vec("reset_press", btn_press, 3'b000);
    check_vec("reset_rep", btn_rep, 3'b000);
    step();
    clr = 1'b0;

    // Clean press on ch0 and ch2 together, release after 6 ticks
    align();
    c = cyc;
    btn_raw[0] = 1'b1;
    btn_raw[2] = 1'b1;
    f = flip_at(c);
    $display("cycle %0d: clean press ch0+ch2, level expected at %0d", c, f);
    expect_pulse(f + 1, 0);
    expect_pulse(f + 1, 2);
    wait_until(f - 1);
    check_bit("clean_pre_ch0", btn_level[0], 1'b0);
    wait_until(f);
    check_bit("clean_rise_ch0", btn_level[0], 1'b1);
    check_bit("clean_rise_ch2", btn_level[2], 1'b1);
    wait_until(c + 6 * TP);
    btn_raw[0] = 1'b0;
    btn_raw[2] = 1'b0;
    fr = flip_at(cyc);
    wait_until(fr - 1);
    check_bit("clean_hold_ch0", btn_level[0], 1'b1);
    wait_until(fr);
    check_bit("clean_fall_ch0", btn_level[0], 1'b0);
    check_bit("clean_fall_ch2", btn_level[2], 1'b0);
    wait_until(fr + 4 * TP);

    // Bounce on ch1: 1,0,1,0 for two ticks each, then steady 1
    align();
    c = cyc;
    $display("cycle %0d: bounce ch1", c);
    for (int i = 0; i < 4; i++) begin
      wait_until(c + i * 2 * TP);
      btn_raw[1] = ((i % 2) == 0);
    end
    wait_until(c + 8 * TP - 1);
    check_bit("bounce_mid_ch1", btn_level[1], 1'b0);
    wait_until(c + 8 * TP);
    btn_raw[1] = 1'b1;
    f = flip_at(cyc);
    expect_pulse(f + 1, 1);
    wait_until(f - 1);
    check_bit("bounce_pre_ch1", btn_level[1], 1'b0);
    wait_until(f);
    check_bit("bounce_rise_ch1", btn_level[1], 1'b1);
    wait_until(f + 1);
    btn_raw[1] = 1'b0;
    fr = flip_at(cyc);
    wait_until(fr);
    check_bit("bounce_fall_ch1", btn_level[1], 1'b0);
    wait_until(fr + 4 * TP);

    // Long hold on ch0: press, first repeat after RD ticks, then every RR
    align();
    c = cyc;
    btn_raw[0] = 1'b1;
    f = flip_at(c);
    $display("cycle %0d: long hold ch0, press expected at %0d", c, f + 1);
    expect_pulse(f + 1, 0);
    for (int k = 0; k < 5; k++) expect_rep(f + (RD + k * RR) * TP, 0);
    wait_until(f + 73);
    btn_raw[0] = 1'b0;
    fr = flip_at(cyc);
    wait_until(fr - 1);
    check_bit("hold_still_ch0", btn_level[0], 1'b1);
    wait_until(fr);
    check_bit("hold_fall_ch0", btn_level[0], 1'b0);
    wait_until(fr + 6 * TP);

    // Release on ch2 landing exactly on a due repeat tick
    align();
    c = cyc;
    btn_raw[2] = 1'b1;
    f = flip_at(c);
    $display("cycle %0d: release-at-repeat ch2", c);
    expect_pulse(f + 1, 2);
    expect_rep(f + RD * TP, 2);
    wait_until(f + (RD + RR) * TP - (DEB - 1) * TP - 3);
    btn_raw[2] = 1'b0;
    fr = flip_at(cyc);
    wait_until(fr - 1);
    check_bit("relrep_hold_ch2", btn_level[2], 1'b1);
    wait_until(fr);
    check_bit("relrep_fall_ch2", btn_level[2], 1'b0);
    check_bit("relrep_norep_ch2", btn_rep[2], 1'b0);
    wait_until(fr + 6 * TP);
    // Fresh press afterwards behaves as a first press
    align();
    btn_raw[2] = 1'b1;
    f = flip_at(cyc);
    expect_pulse(f + 1, 2);
    wait_until(f + 1);
    btn_raw[2] = 1'b0;
    fr = flip_at(cyc);
    wait_until(fr);
    check_bit("repress_fall_ch2", btn_level[2], 1'b0);
    wait_until(fr + 4 * TP);

    // Asynchronous clear mid-hold on ch1, button still held afterwards
    align();
    c = cyc;
    btn_raw[1] = 1'b1;
    f = flip_at(c);
    $display("cycle %0d: clear mid-hold ch1", c);
    expect_pulse(f + 1, 1);
    wait_until(f + 8);
    check_bit("preclr_level_ch1", btn_level[1], 1'b1);
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check_vec("clr_level", btn_level, 3'b000);
    check_vec("clr_press", btn_press, 3'b000);
    check_vec("clr_rep", btn_rep, 3'b000);
    repeat (6) step();
    check_vec("clr_held_level", btn_level, 3'b000);
    clr = 1'b0;
    f = flip_at(cyc);
    expect_pulse(f + 1, 1);
    wait_until(f - 1);
    check_bit("postclr_pre_ch1", btn_level[1], 1'b0);
    wait_until(f);
    check_bit("postclr_rise_ch1", btn_level[1], 1'b1);
    wait_until(f + 1);
    btn_raw[1] = 1'b0;
    fr = flip_at(cyc);
    wait_until(fr);
    check_bit("postclr_fall_ch1", btn_level[1], 1'b0);
    wait_until(fr + 6 * TP);

    // Every queued pulse must have appeared
    vectors++;
    assert (press_q.size() == 0) else begin
      miscompares++;
      $error("FAIL press_queue: observed %0d pending expected 0", press_q.size());
    end
    vectors++;
    assert (rep_q.size() == 0) else begin
      miscompares++;
      $error("FAIL rep_queue: observed %0d pending expected 0", rep_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
